// File: rtl/lcd_text_formatter.sv
// ----------------------------------------------------------------------------
// lcd_text_formatter
//
// Purpose:
//   Upstream feeder of the character-LCD driver. It turns the watch's binary
//   hour/min/sec fields and the UI mode into two 16-character ASCII lines.
//   Each field is converted to two decimal digits by repeated subtraction of
//   10, one step per clock. In the set modes, the field being edited blinks.
//
// Optional feature (compile-time macro LCD_FMT_12H_EN):
//   When defined, valid hours are shown in 12-hour form and AM/PM is placed
//   in line1 chars 14-15. When undefined, a 24-hour display is used and
//   chars 14-15 are always spaces.
//
// Parameters:
//   BLINK_DIV   clk cycles per blink half-period (2..65535)
//
// Ports:
//   clk         system clock
//   rst         asynchronous, active-low reset
//   upd         one-cycle request to capture inputs and reformat
//   hour        hours, binary (valid 0..23)
//   min         minutes, binary (valid 0..59)
//   sec         seconds, binary (valid 0..59)
//   mode        00 run, 01 set hour, 10 set min, 11 set sec
//   busy        high while a conversion is in progress
//   done        one-cycle pulse when new line data becomes visible
//   line1_data  ASCII, char i (0 = leftmost) in bits [8i+7:8i]
//   line2_data  ASCII, same packing
// ----------------------------------------------------------------------------
module lcd_text_formatter #(
   parameter int unsigned BLINK_DIV = 50
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         upd,
   input  logic [4:0]   hour,
   input  logic [5:0]   min,
   input  logic [5:0]   sec,
   input  logic [1:0]   mode,
   output logic         busy,
   output logic         done,
   output logic [127:0] line1_data,
   output logic [127:0] line2_data
);

   typedef enum logic [2:0] {IDLE, CONV_H, CONV_M, CONV_S, WRITE} state_t;

   // String literals are packed with the first character in the MSBs; the
   // line buffers want char 0 in the LSBs, so reverse the byte order.
   function automatic logic [127:0] rev16(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = s[8*(15-i) +: 8];
      return r;
   endfunction

   function automatic logic [7:0] dig(input logic [3:0] d);
      return 8'h30 + {4'h0, d};
   endfunction

   localparam logic [15:0]  BLINK_LAST = 16'(BLINK_DIV - 1);
   localparam logic [127:0] LINE1_RST  = rev16("TIME  --:--:--  ");
   localparam logic [127:0] LINE2_RUN  = rev16("MODE: RUN       ");
   localparam logic [127:0] LINE2_HOUR = rev16("MODE: SET HOUR  ");
   localparam logic [127:0] LINE2_MIN  = rev16("MODE: SET MIN   ");
   localparam logic [127:0] LINE2_SEC  = rev16("MODE: SET SEC   ");

   state_t       state, state_next;
   logic         advance;
   logic [5:0]   rem;
   logic [3:0]   tens;
   logic [5:0]   min_cap, sec_cap;
   logic         h_ok, m_ok, s_ok;
   logic [1:0]   mode_cap;
   logic [3:0]   h_t, h_o, m_t, m_o, s_t, s_o;
   logic [15:0]  blink_cnt;
   logic         hidden;
   logic [5:0]   hour_disp;
   logic [127:0] line1_comp, line2_comp;

`ifdef LCD_FMT_12H_EN
   logic pm;

   // The displayed (12-hour) value is what gets converted, so conversion
   // time follows the displayed hour.
   always_comb begin
      hour_disp = {1'b0, hour};
      if (hour == 5'd0)
         hour_disp = 6'd12;
      else if (hour > 5'd12)
         hour_disp = {1'b0, hour} - 6'd12;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         pm <= 1'b0;
      else if (state == IDLE && upd)
         pm <= (hour >= 5'd12);
   end
`else
   assign hour_disp = {1'b0, hour};
`endif

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      advance    = 1'b0;
      case (state)
         IDLE:   if (upd) state_next = CONV_H;
         CONV_H: begin
            advance = !h_ok || (rem < 6'd10);
            if (advance) state_next = CONV_M;
         end
         CONV_M: begin
            advance = !m_ok || (rem < 6'd10);
            if (advance) state_next = CONV_S;
         end
         CONV_S: begin
            advance = !s_ok || (rem < 6'd10);
            if (advance) state_next = WRITE;
         end
         WRITE:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // ---------------- Blink timebase ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         blink_cnt <= '0;
         hidden    <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
         blink_cnt <= '0;
         hidden    <= ~hidden;
      end else begin
         blink_cnt <= blink_cnt + 16'd1;
      end
   end

   // ---------------- Line composition ----------------
   always_comb begin
      line1_comp = LINE1_RST;
      if (h_ok) begin
         line1_comp[8*6 +: 8] = dig(h_t);
         line1_comp[8*7 +: 8] = dig(h_o);
      end
      if (m_ok) begin
         line1_comp[8*9  +: 8] = dig(m_t);
         line1_comp[8*10 +: 8] = dig(m_o);
      end
      if (s_ok) begin
         line1_comp[8*12 +: 8] = dig(s_t);
         line1_comp[8*13 +: 8] = dig(s_o);
      end
`ifdef LCD_FMT_12H_EN
      if (h_ok) begin
         line1_comp[8*14 +: 8] = pm ? 8'h50 : 8'h41;
         line1_comp[8*15 +: 8] = 8'h4D;
      end
`endif
      // Run mode (00) never blanks anything.
      if (hidden) begin
         case (mode_cap)
            2'b01: begin
               line1_comp[8*6 +: 8] = 8'h20;
               line1_comp[8*7 +: 8] = 8'h20;
            end
            2'b10: begin
               line1_comp[8*9  +: 8] = 8'h20;
               line1_comp[8*10 +: 8] = 8'h20;
            end
            2'b11: begin
               line1_comp[8*12 +: 8] = 8'h20;
               line1_comp[8*13 +: 8] = 8'h20;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      case (mode_cap)
         2'b01:   line2_comp = LINE2_HOUR;
         2'b10:   line2_comp = LINE2_MIN;
         2'b11:   line2_comp = LINE2_SEC;
         default: line2_comp = LINE2_RUN;
      endcase
   end

   // ---------------- Datapath ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy       <= 1'b0;
         done       <= 1'b0;
         line1_data <= LINE1_RST;
         line2_data <= LINE2_RUN;
         rem        <= '0;
         tens       <= '0;
         min_cap    <= '0;
         sec_cap    <= '0;
         h_ok       <= 1'b0;
         m_ok       <= 1'b0;
         s_ok       <= 1'b0;
         mode_cap   <= 2'b00;
         h_t        <= '0;
         h_o        <= '0;
         m_t        <= '0;
         m_o        <= '0;
         s_t        <= '0;
         s_o        <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               // Refreshing every idle cycle picks up a blink toggle one
               // edge after it happens; otherwise the value is unchanged.
               line1_data <= line1_comp;
               if (upd) begin
                  busy     <= 1'b1;
                  mode_cap <= mode;
                  min_cap  <= min;
                  sec_cap  <= sec;
                  h_ok     <= (hour <= 5'd23);
                  m_ok     <= (min <= 6'd59);
                  s_ok     <= (sec <= 6'd59);
                  rem      <= hour_disp;
                  tens     <= '0;
               end
            end
            CONV_H, CONV_M, CONV_S: begin
               if (advance) begin
                  tens <= '0;
                  case (state)
                     CONV_H: begin
                        h_t <= tens;
                        h_o <= rem[3:0];
                        rem <= min_cap;
                     end
                     CONV_M: begin
                        m_t <= tens;
                        m_o <= rem[3:0];
                        rem <= sec_cap;
                     end
                     default: begin
                        s_t <= tens;
                        s_o <= rem[3:0];
                     end
                  endcase
               end else begin
                  rem  <= rem - 6'd10;
                  tens <= tens + 4'd1;
               end
            end
            WRITE: begin
               line1_data <= line1_comp;
               line2_data <= line2_comp;
               done       <= 1'b1;
               busy       <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_text_formatter.sv
// ----------------------------------------------------------------------------
// tb_lcd_text_formatter
//
// Scoreboard bench for lcd_text_formatter. The driver issues update requests
// (directed then random) and pushes the expected lines and busy length, as
// computed by a string-level reference model, into a queue. A monitor on the
// falling clock edge pops an entry on every done pulse, and while idle checks
// the displayed lines against the expected blink phase.
// ----------------------------------------------------------------------------
module tb_lcd_text_formatter;

   localparam int BLINK_DIV = 4;

   logic         clk  = 1'b0;
   logic         rst  = 1'b0;
   logic         upd  = 1'b0;
   logic [4:0]   hour = '0;
   logic [5:0]   min  = '0;
   logic [5:0]   sec  = '0;
   logic [1:0]   mode = '0;
   logic         busy, done;
   logic [127:0] line1_data, line2_data;

   lcd_text_formatter #(.BLINK_DIV(BLINK_DIV)) dut (
      .clk        (clk),
      .rst        (rst),
      .upd        (upd),
      .hour       (hour),
      .min        (min),
      .sec        (sec),
      .mode       (mode),
      .busy       (busy),
      .done       (done),
      .line1_data (line1_data),
      .line2_data (line2_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] l1_vis;
      logic [127:0] l1_hid;
      logic [127:0] l2;
      int           cycles;
   } exp_t;

   exp_t sb[$];
   exp_t shown;
   int   passed = 0;
   int   total  = 0;
   int   edges  = 0;

   // Edges since reset release: the blink phase after edge k is (k/BLINK_DIV)%2.
   always @(posedge clk or negedge rst)
      if (!rst) edges <= 0;
      else      edges <= edges + 1;

   function automatic logic [127:0] pack(input string s);
      logic [127:0] v;
      v = '0;
      for (int i = 0; i < 16; i++) v[8*i +: 8] = s[i];
      return v;
   endfunction

   function automatic string two(input bit ok, input int v);
      return ok ? $sformatf("%02d", v) : "--";
   endfunction

   function automatic exp_t model(input int h, input int m, input int s, input int md);
      exp_t  e;
      bit    h_ok, m_ok, s_ok;
      int    hd;
      string ampm, hs, ms, ss;
      h_ok = (h <= 23);
      m_ok = (m <= 59);
      s_ok = (s <= 59);
      hd   = h;
      ampm = "  ";
`ifdef LCD_FMT_12H_EN
      if (h_ok) begin
         hd   = (h % 12 == 0) ? 12 : h % 12;
         ampm = (h >= 12) ? "PM" : "AM";
      end
`endif
      hs = two(h_ok, hd);
      ms = two(m_ok, m);
      ss = two(s_ok, s);
      e.l1_vis = pack($sformatf("TIME  %s:%s:%s%s", hs, ms, ss, ampm));
      case (md)
         1:       e.l1_hid = pack($sformatf("TIME    :%s:%s%s", ms, ss, ampm));
         2:       e.l1_hid = pack($sformatf("TIME  %s:  :%s%s", hs, ss, ampm));
         3:       e.l1_hid = pack($sformatf("TIME  %s:%s:  %s", hs, ms, ampm));
         default: e.l1_hid = e.l1_vis;
      endcase
      case (md)
         1:       e.l2 = pack("MODE: SET HOUR  ");
         2:       e.l2 = pack("MODE: SET MIN   ");
         3:       e.l2 = pack("MODE: SET SEC   ");
         default: e.l2 = pack("MODE: RUN       ");
      endcase
      e.cycles = (h_ok ? hd / 10 + 1 : 1) + (m_ok ? m / 10 + 1 : 1) + (s_ok ? s / 10 + 1 : 1) + 1;
      return e;
   endfunction

   function automatic exp_t reset_exp();
      exp_t e;
      e.l1_vis = pack("TIME  --:--:--  ");
      e.l1_hid = e.l1_vis;
      e.l2     = pack("MODE: RUN       ");
      e.cycles = 0;
      return e;
   endfunction

   task automatic chk(input string name, input bit ok, input logic [127:0] act, input logic [127:0] req);
      total++;
      if (ok) passed++;
      else $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
   endtask

   // ---------------- Monitor ----------------
   initial begin
      int           busy_cnt;
      logic [127:0] exp1;
      busy_cnt = 0;
      shown    = reset_exp();
      forever begin
         @(negedge clk);
         if (!rst) begin
            sb.delete();
            shown    = reset_exp();
            busy_cnt = 0;
         end else begin
            if (busy) busy_cnt++;
            if (done) begin
               chk("done_expected", sb.size() > 0, 128'(sb.size()), 128'd1);
               if (sb.size() > 0) begin
                  shown = sb.pop_front();
                  chk("busy_cycles", busy_cnt == shown.cycles, 128'(busy_cnt), 128'(shown.cycles));
               end
               busy_cnt = 0;
            end
            if (!busy) begin
               // Displayed line reflects the phase held before the last edge.
               exp1 = (edges > 0 && ((edges - 1) / BLINK_DIV) % 2 == 1) ? shown.l1_hid : shown.l1_vis;
               chk("line1", line1_data == exp1, line1_data, exp1);
               chk("line2", line2_data == shown.l2, line2_data, shown.l2);
            end
         end
      end
   end

   // ---------------- Driver ----------------
   task automatic wait_idle();
      int t;
      t = 0;
      @(negedge clk);
      while (busy && t < 400) begin
         @(negedge clk);
         t++;
      end
      chk("idle_reached", !busy, 128'(busy), 128'd0);
   endtask

   task automatic do_upd(input int h, input int m, input int s, input int md,
                         input bit upd_in_write, input int gap);
      exp_t e;
      repeat (gap) @(negedge clk);
      wait_idle();
      e    = model(h, m, s, md);
      hour = 5'(h);
      min  = 6'(m);
      sec  = 6'(s);
      mode = 2'(md);
      upd  = 1'b1;
      sb.push_back(e);
      $display("upd %0d:%0d:%0d mode=%0d expect %0d busy cycles", h, m, s, md, e.cycles);
      @(negedge clk);
      upd = 1'b0;
      if (upd_in_write) begin
         repeat (e.cycles - 1) @(negedge clk);
         hour = 5'd1;
         min  = 6'd2;
         sec  = 6'd3;
         upd  = 1'b1;
         @(negedge clk);
         upd = 1'b0;
      end
   endtask

   initial begin
      int dh [7] = '{12, 25, 8, 0, 13, 23, 9};
      int dm [7] = '{34, 60, 5, 0, 59, 0, 45};
      int ds [7] = '{56, 7, 9, 0, 59, 31, 63};
      int dmo[7] = '{0, 0, 2, 1, 3, 0, 1};
      int dgp[7] = '{0, 0, 0, 20, 3, 5, 0};

      repeat (3) @(negedge clk);
      chk("rst_line1", line1_data == pack("TIME  --:--:--  "), line1_data, pack("TIME  --:--:--  "));
      chk("rst_line2", line2_data == pack("MODE: RUN       "), line2_data, pack("MODE: RUN       "));
      chk("rst_busy", busy == 1'b0, 128'(busy), 128'd0);
      chk("rst_done", done == 1'b0, 128'(done), 128'd0);
      #1 rst = 1'b1;

      for (int k = 0; k < 7; k++)
         do_upd(dh[k], dm[k], ds[k], dmo[k], (k == 4), dgp[k]);
      repeat (20) @(negedge clk);

      for (int k = 0; k < 40; k++)
         do_upd($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63),
                $urandom_range(0, 3), ($urandom_range(0, 3) == 0), $urandom_range(0, 6));

      // A request during busy must be dropped, not queued.
      do_upd(7, 8, 9, 0, 1'b0, 2);
      @(negedge clk);
      hour = 5'd20;
      min  = 6'd21;
      sec  = 6'd22;
      upd  = 1'b1;
      @(negedge clk);
      upd = 1'b0;

      // Reset in the middle of a long conversion.
      do_upd(23, 59, 59, 3, 1'b0, 2);
      repeat (4) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("midrst_line1", line1_data == pack("TIME  --:--:--  "), line1_data, pack("TIME  --:--:--  "));
      chk("midrst_line2", line2_data == pack("MODE: RUN       "), line2_data, pack("MODE: RUN       "));
      chk("midrst_busy", busy == 1'b0, 128'(busy), 128'd0);
      chk("midrst_done", done == 1'b0, 128'(done), 128'd0);
      @(negedge clk);
      @(negedge clk);
      #1 rst = 1'b1;
      repeat (10) @(negedge clk);

      do_upd(11, 22, 33, 2, 1'b0, 0);
      wait_idle();
      repeat (12) @(negedge clk);
      chk("scoreboard_drained", sb.size() == 0, 128'(sb.size()), 128'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", passed, total);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/lcd_text_formatter.md
Name: lcd_text_formatter

Overview:
Upstream feeder of the character-LCD driver. Converts the watch's binary time fields and the current UI mode into two 16-character ASCII line buffers, line1_data and line2_data, which the LCD driver streams to the panel. Digit conversion is sequential (repeated subtraction). In set modes, the field being edited blinks.

Parameters:
BLINK_DIV, 50, clk cycles per blink half-period; legal range 2..65535.

Ports:
clk  input  1  system clock (same clock as the LCD driver)
rst  input  1  asynchronous, active-low reset
upd  input  1  one-cycle request to capture inputs and reformat
hour  input  5  hours, binary, valid 0..23
min  input  6  minutes, binary, valid 0..59
sec  input  6  seconds, binary, valid 0..59
mode  input  2  00 run, 01 set hour, 10 set min, 11 set sec
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when new line data becomes visible
line1_data  output  128  ASCII; char i (0 = leftmost) in bits [8i+7:8i]
line2_data  output  128  ASCII; same packing

Behaviour:
- Reset (async, rst=0):
  - line1_data = "TIME  --:--:--  ", line2_data = "MODE: RUN       ".
  - busy=0, done=0, blink phase=visible, blink counter=0, FSM=IDLE.
  - Latched digits = invalid ("--").
- FSM states: IDLE, CONV_H, CONV_M, CONV_S, WRITE.
- IDLE with upd=1 at an edge:
  - Capture hour/min/sec/mode.
  - Fields out of range (hour>23, min>59, sec>59) are flagged invalid.
  - Go to CONV_H; busy=1 from that edge.
- CONV_x, each cycle:
  - If remainder >= 10: subtract 10 and increment tens.
  - Else: latch tens/ones and advance to the next state (CONV_H -> CONV_M -> CONV_S -> WRITE).
  - Invalid fields take exactly 1 cycle.
  - Cycles spent in CONV_x = tens+1.
- WRITE (1 cycle):
  - Compose both lines from the latched digits, captured mode and current blink phase.
  - At the edge leaving WRITE: line data updates, done=1 for one cycle, busy=0, FSM=IDLE.
  - Total busy cycles = (tH+1)+(tM+1)+(tS+1)+1.
- upd while busy: ignored, not queued. upd in the same cycle as the busy-falling edge: ignored.
- Line formats:
  - line1 = "TIME  HH:MM:SS  "; invalid field shows "--".
  - line2 by captured mode: "MODE: RUN       ", "MODE: SET HOUR  ", "MODE: SET MIN   ", "MODE: SET SEC   ".
- Blink:
  - Free-running counter 0..BLINK_DIV-1; phase toggles on wrap.
  - Captured mode != run and phase = hidden: the edited field's two chars become spaces (0x20).
  - Phase toggle while IDLE: line1_data is rewritten at the next edge from latched data, with no done pulse.
  - Phase toggle while busy: no immediate rewrite; WRITE uses the phase current at that cycle.
  - Captured mode = run: line data is unaffected by phase.
- Reset asserted mid-conversion: conversion aborts, all outputs return to reset values immediately.

Optional Feature:
LCD_FMT_12H_EN
- Defined:
  - Valid hours are shown in 12-hour form: 0 -> "12" + "AM", 1..11 -> "01".."11" + "AM", 12 -> "12" + "PM", 13..23 -> "01".."11" + "PM".
  - AM/PM goes in line1 chars 14-15.
  - Conversion is applied before CONV_H; cycle count uses the displayed hour.
  - Invalid hour shows "--" and "  " in chars 14-15.
- Undefined: 24-hour display; chars 14-15 are always spaces.

Test Plan:
- Reset released, no upd -> line1="TIME  --:--:--  ", line2="MODE: RUN       ", busy=0, done=0.
- upd with 12:34:56, mode=00 -> busy for 13 cycles, then done pulse; line1="TIME  12:34:56  ".
- upd with 25:60:07 -> line1="TIME  --:--:07  ", busy for 4 cycles.
- upd with 08:05:09, mode=10, BLINK_DIV=4 -> chars 9-10 alternate "05" / "  " every 4 cycles; line2="MODE: SET MIN   "; no done on blink toggles.
- Second upd during busy, then rst pulse mid-conversion -> second upd ignored; after reset, outputs equal reset values and busy=0.
- With LCD_FMT_12H_EN, hour=0 then hour=13 -> "12...AM" then "01...PM" in chars 6-7 / 14-15.
